// File: rtl/bus_reg_bank_pkg.sv
// rtl/bus_reg_bank_pkg.sv - op codes and op type shared by the register bank
package bus_reg_bank_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'b000;
  localparam op_t OP_LOAD = 3'b001;
  localparam op_t OP_INC  = 3'b010;
  localparam op_t OP_DEC  = 3'b011;
  localparam op_t OP_SHL  = 3'b100;
  localparam op_t OP_SHR  = 3'b101;
  localparam op_t OP_CLR  = 3'b110;
  localparam op_t OP_ROL  = 3'b111;

endpackage

// File: rtl/bus_reg_bank_reg_op_unit.sv
// rtl/bus_reg_bank_reg_op_unit.sv - combinational next-value, carry and zero for one register op
module reg_op_unit
  import bus_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_old,
  input  logic [WIDTH-1:0] i_din,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_next,
  output logic             o_carry,
  output logic             o_zero
);

  // Unrecognised codes fall through to default and leave the value untouched.
  always_comb begin
    o_next  = i_old;
    o_carry = 1'b0;
    case (i_op)
      OP_LOAD: o_next = i_din;
      OP_INC:  {o_carry, o_next} = {1'b0, i_old} + (WIDTH+1)'(1);
      OP_DEC: begin
        o_next  = i_old - WIDTH'(1);
        o_carry = (i_old == '0);
      end
      OP_SHL:  {o_carry, o_next} = {i_old, 1'b0};
      OP_SHR:  {o_next, o_carry} = {1'b0, i_old};
      OP_CLR:  o_next = '0;
      OP_ROL: begin
        o_next  = {i_old[WIDTH-2:0], i_old[WIDTH-1]};
        o_carry = i_old[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign o_zero = (o_next == '0);

endmodule

// File: rtl/bus_reg_bank.sv
// rtl/bus_reg_bank.sv - register bank with one write op per cycle and two tri-state read ports
module bus_reg_bank
  import bus_reg_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] din,
  input  logic             ta,
  input  logic [AW-1:0]    raddr_a,
  input  logic             tb,
  input  logic [AW-1:0]    raddr_b,
  output tri   [WIDTH-1:0] bus_a,
  output tri   [WIDTH-1:0] bus_b,
  output logic             carry,
  output logic             zero
);

  // One spare bit so the range compare stays meaningful when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_carry;
  logic             r_zero;

  logic             w_wvalid;
  logic             w_exec;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;
  logic             w_zero;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_wvalid = ({1'b0, waddr} < DEPTH_W);
  assign w_exec   = w_wvalid && (op != OP_HOLD);
  assign w_old    = w_wvalid ? r_regs[waddr] : '0;

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .i_old   (w_old),
    .i_din   (din),
    .i_op    (op),
    .o_next  (w_next),
    .o_carry (w_carry),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_exec) begin
      r_regs[waddr] <= w_next;
      r_carry       <= w_carry;
      r_zero        <= w_zero;
    end
  end

  // Out-of-range read addresses put zeros on an enabled bus rather than stale data.
  assign w_rd_a = ({1'b0, raddr_a} < DEPTH_W) ? r_regs[raddr_a] : '0;
  assign w_rd_b = ({1'b0, raddr_b} < DEPTH_W) ? r_regs[raddr_b] : '0;

  assign bus_a = ta ? w_rd_a : 'z;
  assign bus_b = tb ? w_rd_b : 'z;

  assign carry = r_carry;
  assign zero  = r_zero;

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb/tb_bus_reg_bank.sv - scoreboard bench for bus_reg_bank at DEPTH=4 and DEPTH=3
module tb_bus_reg_bank;

  localparam logic [2:0] C_HOLD = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_INC  = 3'd2;
  localparam logic [2:0] C_DEC  = 3'd3;
  localparam logic [2:0] C_SHL  = 3'd4;
  localparam logic [2:0] C_SHR  = 3'd5;
  localparam logic [2:0] C_CLR  = 3'd6;
  localparam logic [2:0] C_ROL  = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] op;
  logic [1:0] waddr;
  logic [7:0] din;
  logic       ta;
  logic [1:0] raddr_a;
  logic       tb;
  logic [1:0] raddr_b;
  wire  [7:0] bus_a4, bus_b4, bus_a3, bus_b3;
  logic       carry4, zero4, carry3, zero3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] v4;
    logic       c4;
    logic       z4;
    logic [7:0] v3;
    logic       c3;
    logic       z3;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] m4 [4];
  logic [7:0] m3 [3];
  logic       mc4, mz4, mc3, mz3;

  always #5 clk = ~clk;

  bus_reg_bank #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .waddr(waddr), .din(din),
    .ta(ta), .raddr_a(raddr_a), .tb(tb), .raddr_b(raddr_b),
    .bus_a(bus_a4), .bus_b(bus_b4), .carry(carry4), .zero(zero4)
  );

  bus_reg_bank #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .op(op), .waddr(waddr), .din(din),
    .ta(ta), .raddr_a(raddr_a), .tb(tb), .raddr_b(raddr_b),
    .bus_a(bus_a3), .bus_b(bus_b3), .carry(carry3), .zero(zero3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [7:0] old, input logic [7:0] d,
                                output logic [7:0] nx, output logic c, output bit ex);
    nx = old;
    c  = 1'b0;
    ex = 1'b1;
    case (o)
      C_LOAD: nx = d;
      C_INC:  begin nx = old + 8'd1; c = (old == 8'hFF); end
      C_DEC:  begin nx = old - 8'd1; c = (old == 8'h00); end
      C_SHL:  begin nx = old << 1; c = old[7]; end
      C_SHR:  begin nx = old >> 1; c = old[0]; end
      C_CLR:  nx = 8'h00;
      C_ROL:  begin nx = (old << 1) | (old >> 7); c = old[7]; end
      default: ex = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m4[i] = 8'h00;
    for (int i = 0; i < 3; i++) m3[i] = 8'h00;
    mc4 = 1'b0; mz4 = 1'b0; mc3 = 1'b0; mz3 = 1'b0;
  endtask

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check_val("reg4", {24'b0, bus_a4}, {24'b0, e.v4});
      check_val("carry4", {31'b0, carry4}, {31'b0, e.c4});
      check_val("zero4", {31'b0, zero4}, {31'b0, e.z4});
      check_val("reg3", {24'b0, bus_a3}, {24'b0, e.v3});
      check_val("carry3", {31'b0, carry3}, {31'b0, e.c3});
      check_val("zero3", {31'b0, zero3}, {31'b0, e.z3});
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d);
    exp_t       e;
    logic [7:0] old4, nx;
    logic       c;
    bit         ex;
    @(negedge clk);
    op = o; waddr = a; din = d; ta = 1'b1; raddr_a = a;
    old4 = m4[a];
    model(o, m4[a], d, nx, c, ex);
    if (ex) begin m4[a] = nx; mc4 = c; mz4 = (nx == 8'h00); end
    if (a < 2'd3) begin
      model(o, m3[a], d, nx, c, ex);
      if (ex) begin m3[a] = nx; mc3 = c; mz3 = (nx == 8'h00); end
    end
    e.addr = a; e.v4 = m4[a]; e.c4 = mc4; e.z4 = mz4;
    e.v3 = (a < 2'd3) ? m3[a] : 8'h00; e.c3 = mc3; e.z3 = mz3;
    sbq.push_back(e);
    #1 check_val("rdw_old", {24'b0, bus_a4}, {24'b0, old4});
    @(posedge clk);
    #1 op = C_HOLD;
    #1 check_out();
  endtask

  initial begin
    rst_n = 1'b0; op = C_HOLD; waddr = 2'd0; din = 8'h00;
    ta = 1'b1; raddr_a = 2'd0; tb = 1'b1; raddr_b = 2'd3;
    model_reset();
    #3;
    check_val("rst_bus_a", {24'b0, bus_a4}, 32'h00);
    check_val("rst_bus_b", {24'b0, bus_b4}, 32'h00);
    check_val("rst_oor_bus_b3", {24'b0, bus_b3}, 32'h00);
    check_val("rst_carry", {31'b0, carry4}, 32'd0);
    check_val("rst_zero", {31'b0, zero4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; tb = 1'b0;

    // load and transfer
    do_op(C_LOAD, 2'd2, 8'hC3);
    check_val("bus_a_c3", {24'b0, bus_a4}, 32'hC3);
    check_val("bus_b_z", {31'b0, (bus_b4 === 8'hzz)}, 32'd1);
    tb = 1'b1; raddr_b = 2'd2;
    #1;
    check_val("both_a", {24'b0, bus_a4}, 32'hC3);
    check_val("both_b", {24'b0, bus_b4}, 32'hC3);
    check_val("both_b3", {24'b0, bus_b3}, 32'hC3);
    tb = 1'b0;

    // counter wrap, hold, borrow
    do_op(C_LOAD, 2'd1, 8'hFF);
    do_op(C_INC, 2'd1, 8'h00);
    check_val("wrap_val", {24'b0, bus_a4}, 32'h00);
    check_val("wrap_carry", {31'b0, carry4}, 32'd1);
    check_val("wrap_zero", {31'b0, zero4}, 32'd1);
    do_op(C_HOLD, 2'd1, 8'h00);
    do_op(C_DEC, 2'd1, 8'h00);
    check_val("borrow_val", {24'b0, bus_a4}, 32'hFF);
    do_op(C_DEC, 2'd1, 8'h00);

    // shifts and rotate
    do_op(C_LOAD, 2'd3, 8'h81);
    do_op(C_SHL, 2'd3, 8'h00);
    check_val("shl_val", {24'b0, bus_a4}, 32'h02);
    do_op(C_SHR, 2'd3, 8'h00);
    do_op(C_LOAD, 2'd3, 8'h81);
    do_op(C_ROL, 2'd3, 8'h00);
    check_val("rol_val", {24'b0, bus_a4}, 32'h03);
    do_op(C_CLR, 2'd2, 8'h00);

    // out-of-range write on the DEPTH=3 bank keeps its flags
    do_op(C_LOAD, 2'd1, 8'hFF);
    do_op(C_INC, 2'd1, 8'h00);
    do_op(C_INC, 2'd3, 8'h00);
    check_val("oor_carry3", {31'b0, carry3}, 32'd1);
    check_val("oor_zero3", {31'b0, zero3}, 32'd1);

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom));

    // asynchronous reset mid-cycle with an op in flight
    do_op(C_LOAD, 2'd0, 8'h5A);
    do_op(C_LOAD, 2'd1, 8'hFF);
    do_op(C_INC, 2'd1, 8'h00);
    @(posedge clk);
    #2;
    op = C_LOAD; waddr = 2'd0; din = 8'h77; ta = 1'b1; raddr_a = 2'd0;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_bus_a", {24'b0, bus_a4}, 32'h00);
    check_val("mid_rst_carry", {31'b0, carry4}, 32'd0);
    check_val("mid_rst_zero", {31'b0, zero4}, 32'd0);
    @(negedge clk);
    check_val("rst_discard", {24'b0, bus_a4}, 32'h00);
    op = C_HOLD;
    rst_n = 1'b1;
    model_reset();
    do_op(C_DEC, 2'd0, 8'h00);

    if (sbq.size() != 0) check_val("sb_leftover", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
